// File: rtl/qdrc_phy_sram_responder_pkg.sv
// qdrc_phy_sram_responder_pkg
//   Shared definitions for the QDR-II BL4 SRAM responder: port FSM state
//   encoding, beat indices within a stored burst entry, and calibration
//   pattern bits returned for unwritten entries when
//   QDRC_SRAM_INIT_PATTERN_EN is defined.
package qdrc_phy_sram_responder_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } port_st_e;

  // A stored entry packs the four beats LSB first: beat0 at [0 +: DATA_WIDTH].
  localparam int BEATS = 4;
  localparam int BEAT0 = 0;
  localparam int BEAT1 = 1;
  localparam int BEAT2 = 2;
  localparam int BEAT3 = 3;

  // Calibration pattern: every rise beat all-ones, every fall beat all-zeros.
  localparam logic CAL_RISE_BIT = 1'b1;
  localparam logic CAL_FALL_BIT = 1'b0;
endpackage

// File: rtl/qdrc_phy_sram_responder_if.sv
// qdrc_phy_sram_responder_if
//   PHY-side QDR-II bus between controller (master) and SRAM responder (slave).
//   master drives: qdr_w_n, qdr_r_n, qdr_sa, qdr_d_rise/fall, qdr_bw_n_rise/fall
//   slave drives : qdr_q_rise/fall, qdr_q_valid, proto_err
interface qdrc_phy_sram_responder_if #(
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int ADDR_WIDTH = 21
);
  logic                  qdr_w_n;
  logic                  qdr_r_n;
  logic [ADDR_WIDTH-1:0] qdr_sa;
  logic [DATA_WIDTH-1:0] qdr_d_rise;
  logic [DATA_WIDTH-1:0] qdr_d_fall;
  logic [BW_WIDTH-1:0]   qdr_bw_n_rise;
  logic [BW_WIDTH-1:0]   qdr_bw_n_fall;
  logic [DATA_WIDTH-1:0] qdr_q_rise;
  logic [DATA_WIDTH-1:0] qdr_q_fall;
  logic                  qdr_q_valid;
  logic                  proto_err;

  modport master (
    output qdr_w_n, qdr_r_n, qdr_sa, qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall,
    input  qdr_q_rise, qdr_q_fall, qdr_q_valid, proto_err
  );
  modport slave (
    input  qdr_w_n, qdr_r_n, qdr_sa, qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall,
    output qdr_q_rise, qdr_q_fall, qdr_q_valid, proto_err
  );
endinterface

// File: rtl/qdrc_phy_sram_rd_pipe.sv
// qdrc_phy_sram_rd_pipe
//   Read latency pipe plus beat-pair serialiser. A pushed 4-beat entry is
//   registered on the push edge, travels READ_LATENCY-1 stages, then drives
//   beats 0/1 for one cycle and beats 2/3 the next with q_valid high on both.
//   Outputs are registered and forced to zero outside valid cycles.
//   Ports: clk0, reset (async high), push, entry[4*DATA_WIDTH], q_rise, q_fall, q_valid.
//   READ_LATENCY must be 2..15.
module qdrc_phy_sram_rd_pipe
  import qdrc_phy_sram_responder_pkg::*;
#(
  parameter int DATA_WIDTH   = 36,
  parameter int READ_LATENCY = 3
) (
  input  logic                        clk0,
  input  logic                        reset,
  input  logic                        push,
  input  logic [BEATS*DATA_WIDTH-1:0] entry,
  output logic [DATA_WIDTH-1:0]       q_rise,
  output logic [DATA_WIDTH-1:0]       q_fall,
  output logic                        q_valid
);
  // Stage 1 is the registered array read; the output flops add the final cycle.
  localparam int STAGES = READ_LATENCY - 1;
  localparam int EW     = BEATS * DATA_WIDTH;

  logic [STAGES:1]         vld_pipe_q;
  logic [EW-1:0]           dat_pipe_q [STAGES:1];
  logic                    hi_vld_q, hi_vld_d;
  logic [2*DATA_WIDTH-1:0] hi_dat_q, hi_dat_d;
  logic [DATA_WIDTH-1:0]   q_rise_q, q_rise_d, q_fall_q, q_fall_d;
  logic                    q_vld_q, q_vld_d;

  always_comb begin
    q_rise_d = '0;
    q_fall_d = '0;
    q_vld_d  = 1'b0;
    hi_vld_d = 1'b0;
    hi_dat_d = hi_dat_q;
    if (vld_pipe_q[STAGES]) begin
      q_rise_d = dat_pipe_q[STAGES][BEAT0*DATA_WIDTH +: DATA_WIDTH];
      q_fall_d = dat_pipe_q[STAGES][BEAT1*DATA_WIDTH +: DATA_WIDTH];
      q_vld_d  = 1'b1;
      hi_vld_d = 1'b1;
      hi_dat_d = dat_pipe_q[STAGES][BEAT2*DATA_WIDTH +: 2*DATA_WIDTH];
    end else if (hi_vld_q) begin
      // Second half of the burst; the read FSM guarantees no new entry lands here.
      q_rise_d = hi_dat_q[0 +: DATA_WIDTH];
      q_fall_d = hi_dat_q[DATA_WIDTH +: DATA_WIDTH];
      q_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      for (int s = 1; s <= STAGES; s++) dat_pipe_q[s] <= '0;
      hi_vld_q <= 1'b0;
      hi_dat_q <= '0;
      q_rise_q <= '0;
      q_fall_q <= '0;
      q_vld_q  <= 1'b0;
    end else begin
      vld_pipe_q[1] <= push;
      dat_pipe_q[1] <= entry;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
      hi_vld_q <= hi_vld_d;
      hi_dat_q <= hi_dat_d;
      q_rise_q <= q_rise_d;
      q_fall_q <= q_fall_d;
      q_vld_q  <= q_vld_d;
    end
  end

  assign q_rise  = q_rise_q;
  assign q_fall  = q_fall_q;
  assign q_valid = q_vld_q;
endmodule

// File: rtl/qdrc_phy_sram_responder.sv
// qdrc_phy_sram_responder
//   Memory end of the qdrc PHY: a QDR-II BL4 SRAM model built from real logic.
//   Holds the burst array, the write-port FSM with its holding registers, the
//   read-port FSM and the sticky protocol error flag; read data timing lives in
//   qdrc_phy_sram_rd_pipe.
//   Ports: clk0, reset (async, active high), bus (qdrc_phy_sram_responder_if.slave).
//   Optional: QDRC_SRAM_INIT_PATTERN_EN -- unwritten entries read back as the
//   calibration pattern (rise all-ones, fall all-zeros).
module qdrc_phy_sram_responder
  import qdrc_phy_sram_responder_pkg::*;
#(
  parameter int DATA_WIDTH   = 36,
  parameter int BW_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 21,
  parameter int MEM_AW       = 6,
  parameter int READ_LATENCY = 3
) (
  input  logic                     clk0,
  input  logic                     reset,
  qdrc_phy_sram_responder_if.slave bus
);
  localparam int LANE_W = DATA_WIDTH / BW_WIDTH;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int EW     = BEATS * DATA_WIDTH;

  logic [EW-1:0]         mem [DEPTH];
  port_st_e              wr_st_q, rd_st_q;
  logic [MEM_AW-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_d0_q, wr_d1_q;
  logic [BW_WIDTH-1:0]   wr_bw0_q, wr_bw1_q;
  logic                  err_q;

  logic                  wr_commit, rd_push;
  logic [MEM_AW-1:0]     rd_addr;
  logic [EW-1:0]         wr_beats, wr_new, rd_entry;
  logic [BEATS*BW_WIDTH-1:0] wr_bw_n;
  logic                  unused_sa_hi;

  assign rd_addr      = bus.qdr_sa[MEM_AW-1:0];
  assign unused_sa_hi = ^bus.qdr_sa[ADDR_WIDTH-1:MEM_AW];
  assign wr_commit    = (wr_st_q == ST_BEAT2);
  assign rd_push      = (rd_st_q == ST_IDLE) && !bus.qdr_r_n;

  // Both port FSMs; a command seen in BEAT2 is dropped and flagged while the
  // burst in flight finishes.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      wr_st_q   <= ST_IDLE;
      rd_st_q   <= ST_IDLE;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_d0_q   <= '0;
      wr_d1_q   <= '0;
      wr_bw0_q  <= '1;
      wr_bw1_q  <= '1;
    end else begin
      case (wr_st_q)
        ST_IDLE: if (!bus.qdr_w_n) begin
          wr_st_q   <= ST_BEAT2;
          wr_addr_q <= bus.qdr_sa[MEM_AW-1:0];
          wr_d0_q   <= bus.qdr_d_rise;
          wr_d1_q   <= bus.qdr_d_fall;
          wr_bw0_q  <= bus.qdr_bw_n_rise;
          wr_bw1_q  <= bus.qdr_bw_n_fall;
        end
        default: begin
          wr_st_q <= ST_IDLE;
          if (!bus.qdr_w_n) err_q <= 1'b1;
        end
      endcase
      case (rd_st_q)
        ST_IDLE: if (!bus.qdr_r_n) rd_st_q <= ST_BEAT2;
        default: begin
          rd_st_q <= ST_IDLE;
          if (!bus.qdr_r_n) err_q <= 1'b1;
        end
      endcase
    end
  end

  // Merge the held beats 0/1 and live beats 2/3 into the stored entry lane by lane.
  always_comb begin
    wr_beats = {bus.qdr_d_fall, bus.qdr_d_rise, wr_d1_q, wr_d0_q};
    wr_bw_n  = {bus.qdr_bw_n_fall, bus.qdr_bw_n_rise, wr_bw1_q, wr_bw0_q};
    wr_new   = mem[wr_addr_q];
    for (int b = 0; b < BEATS; b++)
      for (int l = 0; l < BW_WIDTH; l++)
        if (!wr_bw_n[b*BW_WIDTH + l])
          wr_new[b*DATA_WIDTH + l*LANE_W +: LANE_W] = wr_beats[b*DATA_WIDTH + l*LANE_W +: LANE_W];
  end

  // Array is not reset; reset forces wr_st_q to IDLE so a partial burst never lands.
  always_ff @(posedge clk0) begin
    if (wr_commit) mem[wr_addr_q] <= wr_new;
  end

`ifdef QDRC_SRAM_INIT_PATTERN_EN
  localparam logic [EW-1:0] CAL_ENTRY = {{DATA_WIDTH{CAL_FALL_BIT}}, {DATA_WIDTH{CAL_RISE_BIT}},
                                         {DATA_WIDTH{CAL_FALL_BIT}}, {DATA_WIDTH{CAL_RISE_BIT}}};
  logic [DEPTH-1:0] written_q;

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset)          written_q <= '0;
    else if (wr_commit) written_q[wr_addr_q] <= 1'b1;
  end

  always_comb begin
    rd_entry = mem[rd_addr];
    if (!written_q[rd_addr]) rd_entry = CAL_ENTRY;
  end
`else
  assign rd_entry = mem[rd_addr];
`endif

  // Read is sampled before this edge's commit, giving pre-write data for T/T+1.
  qdrc_phy_sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk0   (clk0),
    .reset  (reset),
    .push   (rd_push),
    .entry  (rd_entry),
    .q_rise (bus.qdr_q_rise),
    .q_fall (bus.qdr_q_fall),
    .q_valid(bus.qdr_q_valid)
  );

  assign bus.proto_err = err_q;
endmodule

// File: tb/tb_qdrc_phy_sram_responder.sv
// tb_qdrc_phy_sram_responder
//   Directed, table-driven bench for the QDR-II SRAM responder. Each table row
//   is one clock cycle: inputs driven for that cycle and the outputs expected
//   to be visible during it. Hand sequences cover reset-related corners.
//   Honours QDRC_SRAM_INIT_PATTERN_EN for the post-reset readback values.
module tb_qdrc_phy_sram_responder;
  localparam int DW = 36, BW = 4, AW = 21, MAW = 6, RL = 3;
  localparam int NROWS = 45;

  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] L0Z  = 36'hFFFFFFE00;
  localparam logic [DW-1:0] DA = 36'h111111111, DB = 36'h222222222, DC = 36'h333333333,
                            DD = 36'h444444444, DE = 36'h555555555, DF = 36'h666666666,
                            DG = 36'h777777777, DH = 36'h888888888, DI = 36'h999999999,
                            DJ = 36'hAAAAAAAAA, DK = 36'hBBBBBBBBB, DL = 36'hCCCCCCCCC,
                            DM = 36'hDDDDDDDDD, DN = 36'hEEEEEEEEE, DP = 36'h123456789,
                            DQ = 36'h987654321, DR = 36'h0F0F0F0F0, DS = 36'h5A5A5A5A5;

  typedef struct {
    logic          w_n;
    logic          r_n;
    logic [AW-1:0] sa;
    logic [DW-1:0] dr;
    logic [DW-1:0] df;
    logic [BW-1:0] bwr;
    logic [BW-1:0] bwf;
    logic          ev;
    logic [DW-1:0] er;
    logic [DW-1:0] ef;
    logic          eerr;
  } vec_t;

  logic clk0 = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl [NROWS];

  always #5 clk0 = ~clk0;

  qdrc_phy_sram_responder_if #(.DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  qdrc_phy_sram_responder #(
    .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .READ_LATENCY(RL)
  ) dut (
    .clk0 (clk0),
    .reset(reset),
    .bus  (bus)
  );

  function automatic vec_t row(input logic w_n, input logic r_n, input logic [AW-1:0] sa,
                               input logic [DW-1:0] dr, input logic [DW-1:0] df,
                               input logic [BW-1:0] bwr, input logic [BW-1:0] bwf,
                               input logic ev, input logic [DW-1:0] er, input logic [DW-1:0] ef,
                               input logic eerr);
    vec_t v;
    v.w_n = w_n; v.r_n = r_n; v.sa = sa; v.dr = dr; v.df = df; v.bwr = bwr; v.bwf = bwf;
    v.ev = ev; v.er = er; v.ef = ef; v.eerr = eerr;
    return v;
  endfunction

  function automatic vec_t iv(input logic ev, input logic [DW-1:0] er, input logic [DW-1:0] ef,
                              input logic eerr);
    return row(1'b1, 1'b1, '0, '0, '0, 4'hF, 4'hF, ev, er, ef, eerr);
  endfunction

  function automatic logic [2*DW+1:0] snap();
    return {bus.qdr_q_valid, bus.qdr_q_rise, bus.qdr_q_fall, bus.proto_err};
  endfunction

  task automatic check(input string name, input logic [2*DW+1:0] act, input logic [2*DW+1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,rise,fall,err}=%h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic drive_idle();
    bus.qdr_w_n = 1'b1; bus.qdr_r_n = 1'b1; bus.qdr_sa = '0;
    bus.qdr_d_rise = '0; bus.qdr_d_fall = '0;
    bus.qdr_bw_n_rise = 4'hF; bus.qdr_bw_n_fall = 4'hF;
  endtask

  // Read at the current cycle; check both beat pairs at T+RL and T+RL+1.
  task automatic read_expect(input string name, input logic [AW-1:0] sa,
                             input logic [DW-1:0] r0, input logic [DW-1:0] f0,
                             input logic [DW-1:0] r1, input logic [DW-1:0] f1);
    bus.qdr_r_n = 1'b0; bus.qdr_sa = sa;
    step();
    bus.qdr_r_n = 1'b1;
    for (int k = 1; k < RL; k++) step();
    check({name, "_b01"}, snap(), {1'b1, r0, f0, 1'b0});
    step();
    check({name, "_b23"}, snap(), {1'b1, r1, f1, 1'b0});
    step();
  endtask

  initial begin
    logic [DW-1:0] xr0, xf0, xr1, xf1;
`ifdef QDRC_SRAM_INIT_PATTERN_EN
    xr0 = ONES; xf0 = '0; xr1 = ONES; xf1 = '0;
`else
    xr0 = DA; xf0 = DB; xr1 = DC; xf1 = DD;
`endif

    tbl[0]  = row(0, 1, 5, DA, DB, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[1]  = row(1, 1, 0, DC, DD, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[2]  = row(1, 0, 5, '0, '0, 4'hF, 4'hF, 0, '0, '0, 0);
    tbl[3]  = iv(0, '0, '0, 0);
    tbl[4]  = iv(0, '0, '0, 0);
    tbl[5]  = iv(1, DA, DB, 0);
    tbl[6]  = iv(1, DC, DD, 0);
    tbl[7]  = row(0, 1, 2, ONES, ONES, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[8]  = row(1, 1, 0, ONES, ONES, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[9]  = row(0, 1, 2, '0, '0, 4'hE, 4'hF, 0, '0, '0, 0);
    tbl[10] = row(1, 1, 0, '0, '0, 4'hF, 4'hF, 0, '0, '0, 0);
    tbl[11] = row(1, 0, 2, '0, '0, 4'hF, 4'hF, 0, '0, '0, 0);
    tbl[12] = iv(0, '0, '0, 0);
    tbl[13] = iv(0, '0, '0, 0);
    tbl[14] = iv(1, L0Z, ONES, 0);
    tbl[15] = iv(1, ONES, ONES, 0);
    tbl[16] = row(0, 1, 7, DE, DF, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[17] = row(1, 1, 0, DG, DH, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[18] = iv(0, '0, '0, 0);
    tbl[19] = row(0, 0, 7, DI, DJ, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[20] = row(1, 1, 0, DK, DL, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[21] = row(1, 0, 7, '0, '0, 4'hF, 4'hF, 0, '0, '0, 0);
    tbl[22] = iv(1, DE, DF, 0);
    tbl[23] = iv(1, DG, DH, 0);
    tbl[24] = iv(1, DI, DJ, 0);
    tbl[25] = iv(1, DK, DL, 0);
    tbl[26] = row(1, 0, 5, '0, '0, 4'hF, 4'hF, 0, '0, '0, 0);
    tbl[27] = iv(0, '0, '0, 0);
    tbl[28] = row(1, 0, 2, '0, '0, 4'hF, 4'hF, 0, '0, '0, 0);
    tbl[29] = iv(1, DA, DB, 0);
    tbl[30] = row(1, 0, 7, '0, '0, 4'hF, 4'hF, 1, DC, DD, 0);
    tbl[31] = iv(1, L0Z, ONES, 0);
    tbl[32] = iv(1, ONES, ONES, 0);
    tbl[33] = iv(1, DI, DJ, 0);
    tbl[34] = iv(1, DK, DL, 0);
    tbl[35] = iv(0, '0, '0, 0);
    tbl[36] = row(0, 1, 3, DM, DN, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[37] = row(0, 1, 3, DP, DQ, 4'h0, 4'h0, 0, '0, '0, 0);
    tbl[38] = row(1, 1, 0, DR, DS, 4'h0, 4'h0, 0, '0, '0, 1);
    tbl[39] = row(1, 0, 3, '0, '0, 4'hF, 4'hF, 0, '0, '0, 1);
    tbl[40] = iv(0, '0, '0, 1);
    tbl[41] = iv(0, '0, '0, 1);
    tbl[42] = iv(1, DM, DN, 1);
    tbl[43] = iv(1, DP, DQ, 1);
    tbl[44] = iv(0, '0, '0, 1);

    drive_idle();
    reset = 1'b1;
    step();
    step();
    check("reset_state", snap(), '0);
    reset = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      bus.qdr_w_n = tbl[i].w_n;  bus.qdr_r_n = tbl[i].r_n;  bus.qdr_sa = tbl[i].sa;
      bus.qdr_d_rise = tbl[i].dr; bus.qdr_d_fall = tbl[i].df;
      bus.qdr_bw_n_rise = tbl[i].bwr; bus.qdr_bw_n_fall = tbl[i].bwf;
      check($sformatf("row%0d", i), snap(), {tbl[i].ev, tbl[i].er, tbl[i].ef, tbl[i].eerr});
      step();
    end

    // Sticky error cleared only by reset (asynchronously).
    drive_idle();
    reset = 1'b1;
    #1;
    check("reset_clears_err", snap(), '0);
    step();
    reset = 1'b0;

    // Array survives reset; with the init pattern, written flags do not.
    read_expect("post_reset_rd5", 5, xr0, xf0, xr1, xf1);
`ifdef QDRC_SRAM_INIT_PATTERN_EN
    read_expect("unwritten_rd9", 9, ONES, '0, ONES, '0);
`endif

    // Reset during the first valid beat pair kills outputs at once and empties the pipe.
    bus.qdr_r_n = 1'b0; bus.qdr_sa = 5;
    step();
    bus.qdr_r_n = 1'b1;
    for (int k = 1; k < RL; k++) step();
    check("midread_b01", snap(), {1'b1, xr0, xf0, 1'b0});
    #2 reset = 1'b1;
    #1 check("midread_reset_outs", snap(), '0);
    step();
    reset = 1'b0;
    step();
    check("midread_pipe_empty", snap(), '0);

    // Reset in BEAT2 must not commit the partial write.
    bus.qdr_w_n = 1'b0; bus.qdr_sa = 5; bus.qdr_d_rise = DS; bus.qdr_d_fall = DR;
    bus.qdr_bw_n_rise = 4'h0; bus.qdr_bw_n_fall = 4'h0;
    step();
    bus.qdr_w_n = 1'b1; bus.qdr_d_rise = DQ; bus.qdr_d_fall = DP;
    #2 reset = 1'b1;
    step();
    reset = 1'b0;
    drive_idle();
    step();
    read_expect("partial_wr_dropped", 5, xr0, xf0, xr1, xf1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
